// File: rtl/reg_ctr_pkg.sv
// Purpose : shared operation encoding and priority resolution for reg_ctr.
// Latency : n/a (types and a pure function only).
// Backpressure: n/a.
package reg_ctr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LD   = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHR  = 3'd5,
        OP_SHL  = 3'd6
    } op_e;

    // Strict priority cl > ld > {inc, dec} > sr > sl > hold.
    // inc and dec together cancel into a hold that still blocks the shifts,
    // which is why that case returns before sr/sl are looked at.
    function automatic op_e resolve_op(input logic cl, input logic ld,
                                       input logic inc, input logic dec,
                                       input logic sr, input logic sl);
        op_e op;
        op = OP_HOLD;
        if (cl)              op = OP_CLR;
        else if (ld)         op = OP_LD;
        else if (inc && dec) op = OP_HOLD;
        else if (inc)        op = OP_INC;
        else if (dec)        op = OP_DEC;
        else if (sr)         op = OP_SHR;
        else if (sl)         op = OP_SHL;
        return op;
    endfunction

endpackage

// File: rtl/reg_ctr_if.sv
// Purpose : control/data bundle between a user and the reg_ctr register.
// Latency : n/a (wiring only).
// Backpressure: none; the register accepts an operation every cycle.
// Ports   : controls cl/ld/inc/dec/sr/sl, serial inputs ir/il, load data in;
//           status out (contents), zero, bnd (bound pulse), sout (shifted-out bit).
interface reg_ctr_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  cl;
    logic                  ld;
    logic                  inc;
    logic                  dec;
    logic                  sr;
    logic                  ir;
    logic                  sl;
    logic                  il;
    logic [DATA_WIDTH-1:0] in;
    logic [DATA_WIDTH-1:0] out;
    logic                  zero;
    logic                  bnd;
    logic                  sout;

    modport master (
        output cl, ld, inc, dec, sr, ir, sl, il, in,
        input  out, zero, bnd, sout
    );

    modport slave (
        input  cl, ld, inc, dec, sr, ir, sl, il, in,
        output out, zero, bnd, sout
    );
endinterface

// File: rtl/reg_ctr_next.sv
// Purpose : combinational next value plus bnd/sout flags for one operation.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : op (resolved operation), cur (current contents), din (load data),
//           ir/il (serial inputs); nxt, bnd_nxt, sout_nxt (values to register).
module reg_ctr_next
    import reg_ctr_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] MAX_VALUE   = '1,
    parameter bit                    SATURATE    = 1'b0
) (
    input  op_e                   op,
    input  logic [DATA_WIDTH-1:0] cur,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  ir,
    input  logic                  il,
    output logic [DATA_WIDTH-1:0] nxt,
    output logic                  bnd_nxt,
    output logic                  sout_nxt
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        nxt      = cur;
        bnd_nxt  = 1'b0;
        sout_nxt = 1'b0;
        unique case (op)
            OP_CLR: nxt = RESET_VALUE;
            OP_LD:  nxt = din;
            OP_INC: begin
                // >= rather than == so a shifted or loaded value above the
                // limit still counts as having reached the bound.
                if (cur >= MAX_VALUE) begin
                    bnd_nxt = 1'b1;
                    nxt     = SATURATE ? MAX_VALUE : '0;
                end else begin
                    nxt = cur + ONE;
                end
            end
            OP_DEC: begin
                if (cur == '0) begin
                    bnd_nxt = 1'b1;
                    nxt     = SATURATE ? '0 : MAX_VALUE;
                end else begin
                    nxt = cur - ONE;
                end
            end
            OP_SHR: begin
                nxt      = {ir, cur[DATA_WIDTH-1:1]};
                sout_nxt = cur[0];
            end
            OP_SHL: begin
                nxt      = {cur[DATA_WIDTH-2:0], il};
                sout_nxt = cur[DATA_WIDTH-1];
            end
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/reg_ctr.sv
// Purpose : parametrised load/count/shift register with registered status flags.
// Latency : 1 cycle; an operation sampled on edge N is visible after edge N.
// Backpressure: none; one operation accepted per cycle, never stalls.
// Ports   : clk, rst_n (async active-low), bus (reg_ctr_if slave: controls,
//           load data, out/zero/bnd/sout status).
module reg_ctr
    import reg_ctr_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] MAX_VALUE   = '1,
    parameter bit                    SATURATE    = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_ctr_if.slave bus
);

    op_e                   op;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_nxt;
    logic                  bnd_q;
    logic                  bnd_nxt;
    logic                  sout_q;
    logic                  sout_nxt;

    assign op = resolve_op(bus.cl, bus.ld, bus.inc, bus.dec, bus.sr, bus.sl);

    reg_ctr_next #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VALUE(RESET_VALUE),
        .MAX_VALUE  (MAX_VALUE),
        .SATURATE   (SATURATE)
    ) u_next (
        .op      (op),
        .cur     (out_q),
        .din     (bus.in),
        .ir      (bus.ir),
        .il      (bus.il),
        .nxt     (out_nxt),
        .bnd_nxt (bnd_nxt),
        .sout_nxt(sout_nxt)
    );

    // bnd and sout are rewritten every cycle so they read as single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= RESET_VALUE;
            bnd_q  <= 1'b0;
            sout_q <= 1'b0;
        end else begin
            out_q  <= out_nxt;
            bnd_q  <= bnd_nxt;
            sout_q <= sout_nxt;
        end
    end

    assign bus.out  = out_q;
    assign bus.zero = (out_q == '0);
    assign bus.bnd  = bnd_q;
    assign bus.sout = sout_q;

endmodule

// File: tb/tb_reg_ctr.sv
// Purpose : self-checking bench for reg_ctr over four parameter builds.
// Latency : checks sampled on the falling edge after each active edge.
// Backpressure: n/a.
module tb_reg_ctr;

    // Builds: 0 default 8-bit, 1 wrap MAX=9 RV=0x10, 2 saturate, 3 16-bit.
    localparam int CW  [4] = '{8, 8, 8, 16};
    localparam int CRV [4] = '{0, 16, 0, 0};
    localparam int CMX [4] = '{255, 9, 255, 65535};
    localparam int CSAT[4] = '{0, 0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_ctr_if #(.DATA_WIDTH(8))  bus0 ();
    reg_ctr_if #(.DATA_WIDTH(8))  bus1 ();
    reg_ctr_if #(.DATA_WIDTH(8))  bus2 ();
    reg_ctr_if #(.DATA_WIDTH(16)) bus3 ();

    reg_ctr #(.DATA_WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    reg_ctr #(.DATA_WIDTH(8), .RESET_VALUE(8'h10), .MAX_VALUE(8'd9), .SATURATE(1'b0))
        u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    reg_ctr #(.DATA_WIDTH(8), .RESET_VALUE(8'h00), .MAX_VALUE(8'hFF), .SATURATE(1'b1))
        u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    reg_ctr #(.DATA_WIDTH(16), .MAX_VALUE(16'hFFFF))
        u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    logic [15:0] d_out  [4];
    logic        d_zero [4];
    logic        d_bnd  [4];
    logic        d_sout [4];

    assign d_out[0] = {8'h00, bus0.out};
    assign d_out[1] = {8'h00, bus1.out};
    assign d_out[2] = {8'h00, bus2.out};
    assign d_out[3] = bus3.out;
    assign d_zero[0] = bus0.zero; assign d_zero[1] = bus1.zero;
    assign d_zero[2] = bus2.zero; assign d_zero[3] = bus3.zero;
    assign d_bnd[0]  = bus0.bnd;  assign d_bnd[1]  = bus1.bnd;
    assign d_bnd[2]  = bus2.bnd;  assign d_bnd[3]  = bus3.bnd;
    assign d_sout[0] = bus0.sout; assign d_sout[1] = bus1.sout;
    assign d_sout[2] = bus2.sout; assign d_sout[3] = bus3.sout;

    // Reference state: contents as plain integers, flags as bits.
    int m_out  [4];
    int m_bnd  [4];
    int m_sout [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_out[k] = CRV[k]; m_bnd[k] = 0; m_sout[k] = 0;
        end
    endtask

    task automatic set_if(input logic c, input logic l, input logic i, input logic d,
                          input logic r, input logic irv, input logic s, input logic ilv,
                          input logic [15:0] din);
        bus0.cl = c; bus0.ld = l; bus0.inc = i; bus0.dec = d; bus0.sr = r; bus0.ir = irv; bus0.sl = s; bus0.il = ilv; bus0.in = din[7:0];
        bus1.cl = c; bus1.ld = l; bus1.inc = i; bus1.dec = d; bus1.sr = r; bus1.ir = irv; bus1.sl = s; bus1.il = ilv; bus1.in = din[7:0];
        bus2.cl = c; bus2.ld = l; bus2.inc = i; bus2.dec = d; bus2.sr = r; bus2.ir = irv; bus2.sl = s; bus2.il = ilv; bus2.in = din[7:0];
        bus3.cl = c; bus3.ld = l; bus3.inc = i; bus3.dec = d; bus3.sr = r; bus3.ir = irv; bus3.sl = s; bus3.il = ilv; bus3.in = din;
    endtask

    // Apply one operation for one active edge and advance the reference model.
    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic c, input logic l, input logic i, input logic d,
                         input logic r, input logic irv, input logic s, input logic ilv,
                         input logic [15:0] din);
        set_if(c, l, i, d, r, irv, s, ilv, din);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int o, mask, nb, ns;
            o = m_out[k]; mask = (1 << CW[k]) - 1; nb = 0; ns = 0;
            if (c)           o = CRV[k];
            else if (l)      o = int'(din) & mask;
            else if (i && d) o = o;
            else if (i) begin
                if (o >= CMX[k]) begin nb = 1; o = (CSAT[k] != 0) ? CMX[k] : 0; end
                else o = o + 1;
            end else if (d) begin
                if (o == 0) begin nb = 1; o = (CSAT[k] != 0) ? 0 : CMX[k]; end
                else o = o - 1;
            end else if (r) begin
                ns = o % 2; o = (o / 2) + (int'(irv) << (CW[k] - 1));
            end else if (s) begin
                ns = (o >> (CW[k] - 1)) & 1; o = ((o * 2) + int'(ilv)) & mask;
            end
            m_out[k] = o; m_bnd[k] = nb; m_sout[k] = ns;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d_out[k] !== 16'(CRV[k]) || d_bnd[k] !== 1'b0 || d_sout[k] !== 1'b0) begin
                errors++; $display("FAIL reset_init[%0d] out=%h bnd=%b sout=%b want out=%h bnd=0 sout=0", k, d_out[k], d_bnd[k], d_sout[k], CRV[k]);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h005A);
        checks++;
        if (d_out[0] !== 16'h005A) begin errors++; $display("FAIL ld_5a out=%h want 005a", d_out[0]); end
        checks++;
        if (d_out[1] !== 16'h005A) begin errors++; $display("FAIL ld_above_max out=%h want 005a", d_out[1]); end
        // Leave ld asserted while reset hits: the pending load must be discarded.
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (d_out[0] !== 16'h0000 || d_bnd[0] !== 1'b0 || d_sout[0] !== 1'b0) begin
            errors++; $display("FAIL async_reset out=%h bnd=%b sout=%b want 0000/0/0", d_out[0], d_bnd[0], d_sout[0]);
        end
        checks++;
        if (d_out[1] !== 16'h0010) begin errors++; $display("FAIL reset_value out=%h want 0010", d_out[1]); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (d_out[0] !== 16'h0000) begin errors++; $display("FAIL reset_hold out=%h want 0000", d_out[0]); end
        set_if(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0008);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_out[1] !== 16'h0009 || d_bnd[1] !== 1'b0) begin errors++; $display("FAIL wrap_inc1 out=%h bnd=%b want 0009/0", d_out[1], d_bnd[1]); end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_out[1] !== 16'h0000 || d_bnd[1] !== 1'b1) begin errors++; $display("FAIL wrap_inc2 out=%h bnd=%b want 0000/1", d_out[1], d_bnd[1]); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_bnd[1] !== 1'b0) begin errors++; $display("FAIL wrap_bnd_pulse bnd=%b want 0", d_bnd[1]); end
        drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_out[1] !== 16'h0009 || d_bnd[1] !== 1'b1) begin errors++; $display("FAIL wrap_dec0 out=%h bnd=%b want 0009/1", d_out[1], d_bnd[1]); end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_o [3];
        logic       exp_b [3];
        exp_o = '{8'hFF, 8'hFF, 8'hFF};
        exp_b = '{1'b0, 1'b1, 1'b1};
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h00FE);
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
            checks++;
            if (d_out[2] !== {8'h00, exp_o[n]} || d_bnd[2] !== exp_b[n]) begin
                errors++; $display("FAIL sat_inc%0d out=%h bnd=%b want %h/%b", n, d_out[2], d_bnd[2], exp_o[n], exp_b[n]);
            end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_out[2] !== 16'h0000 || d_bnd[2] !== 1'b1 || d_zero[2] !== 1'b1) begin
            errors++; $display("FAIL sat_dec0 out=%h bnd=%b zero=%b want 0000/1/1", d_out[2], d_bnd[2], d_zero[2]);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 16'h0033);
        checks++;
        if (d_out[1] !== 16'h0010 || d_out[0] !== 16'h0000) begin
            errors++; $display("FAIL prio_clr out1=%h out0=%h want 0010/0000", d_out[1], d_out[0]);
        end
        drive(0, 1, 1, 0, 0, 0, 0, 0, 16'h0033);
        checks++;
        if (d_out[0] !== 16'h0033) begin errors++; $display("FAIL prio_ld out=%h want 0033", d_out[0]); end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0040);
        drive(0, 0, 1, 1, 1, 1, 0, 0, 16'h0000);
        checks++;
        if (d_out[0] !== 16'h0040 || d_sout[0] !== 1'b0 || d_bnd[0] !== 1'b0) begin
            errors++; $display("FAIL prio_incdec out=%h sout=%b bnd=%b want 0040/0/0", d_out[0], d_sout[0], d_bnd[0]);
        end
    endtask

    task automatic test_shift();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'h0081);
        drive(0, 0, 0, 0, 1, 0, 0, 1, 16'h0000);
        checks++;
        if (d_out[0] !== 16'h0040 || d_sout[0] !== 1'b1) begin errors++; $display("FAIL shr out=%h sout=%b want 0040/1", d_out[0], d_sout[0]); end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 16'h0000);
        checks++;
        if (d_out[0] !== 16'h0081 || d_sout[0] !== 1'b0) begin errors++; $display("FAIL shl out=%h sout=%b want 0081/0", d_out[0], d_sout[0]); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        for (int n = 0; n < 8; n++) drive(0, 0, 0, 0, 0, 0, 1, 1, 16'h0000);
        checks++;
        if (d_out[0] !== 16'h00FF) begin errors++; $display("FAIL shl_fill out=%h want 00ff", d_out[0]); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_sout[0] !== 1'b0) begin errors++; $display("FAIL sout_pulse sout=%b want 0", d_sout[0]); end
    endtask

    task automatic test_wide();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
        checks++;
        if (d_out[3] !== 16'h0000 || d_zero[3] !== 1'b1 || d_bnd[3] !== 1'b1) begin
            errors++; $display("FAIL wide_wrap out=%h zero=%b bnd=%b want 0000/1/1", d_out[3], d_zero[3], d_bnd[3]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                  1'($urandom), 16'($urandom));
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (d_out[k] !== 16'(m_out[k]) || d_bnd[k] !== 1'(m_bnd[k]) ||
                    d_sout[k] !== 1'(m_sout[k]) || d_zero[k] !== (m_out[k] == 0)) begin
                    errors++;
                    $display("FAIL rand[%0d] build%0d out=%h bnd=%b sout=%b zero=%b want out=%h bnd=%0d sout=%0d",
                             n, k, d_out[k], d_bnd[k], d_sout[k], d_zero[k], m_out[k], m_bnd[k], m_sout[k]);
                end
            end
        end
    endtask

    initial begin
        set_if(0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        @(negedge clk);
        test_wrap();
        test_saturate();
        test_priority();
        test_shift();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_ctr.md
Name: reg_ctr

Overview:
- Parametrised successor to the 8-bit load/increment register. Generalises width, reset value and wrap limit.
- Adds decrement, clear, serial shift left/right, selectable wrap or saturate arithmetic, and registered status flags.
- Used as a general datapath register, counter, or pointer in the synthesis module set, e.g. as a PC, address counter or shift register in small CPUs and peripherals.

Parameters:
- DATA_WIDTH, 8, register width in bits (>=2).
- RESET_VALUE, 0, value loaded into out on reset and on cl.
- MAX_VALUE, 2**DATA_WIDTH-1, upper count bound for inc/dec; must be <= 2**DATA_WIDTH-1.
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cl  in  1  synchronous clear to RESET_VALUE.
- ld  in  1  parallel load of in.
- inc  in  1  count up by 1.
- dec  in  1  count down by 1.
- sr  in  1  shift right one position.
- ir  in  1  serial bit entering the MSB on sr.
- sl  in  1  shift left one position.
- il  in  1  serial bit entering the LSB on sl.
- in  in  DATA_WIDTH  parallel load data.
- out  out  DATA_WIDTH  register contents (registered).
- zero  out  1  high when out == 0 (combinational from out register).
- bnd  out  1  registered one-cycle pulse: previous cycle's inc/dec hit a bound (wrapped or saturated).
- sout  out  1  registered one-cycle value: bit shifted out by the previous shift (LSB for sr, MSB for sl); 0 otherwise.

Behaviour:
- Reset (rst_n low, asynchronous, immediate): out = RESET_VALUE, bnd = 0, sout = 0. Reset asserted mid-operation discards any pending operation. First operation takes effect on the first rising edge after rst_n deasserts.
- Single-cycle latency: the operation sampled on edge N is visible on out after edge N.
- Strict priority per cycle: cl > ld > {inc, dec} > sr > sl > hold. Only the highest-priority active operation executes.
- Only out changes with the operation. bnd and sout are cleared every cycle unless set by that cycle's operation.
- cl: out = RESET_VALUE.
- ld: out = in. Values above MAX_VALUE are accepted unchanged; no range check.
- inc and dec both high: net hold. out is unchanged, bnd = 0, and lower-priority sr/sl are NOT executed.
- inc only:
  - If out >= MAX_VALUE: wrap mode gives out = 0; saturate mode gives out = MAX_VALUE. bnd pulses 1 in both modes.
  - Otherwise out = out + 1.
- dec only:
  - If out == 0: wrap mode gives out = MAX_VALUE; saturate mode gives out = 0. bnd pulses 1.
  - Otherwise out = out - 1.
- All arithmetic is DATA_WIDTH wide. No carry leaves the block except through bnd.
- sr: out = {ir, out[DATA_WIDTH-1:1]}, sout = old out[0].
- sl: out = {out[DATA_WIDTH-2:0], il}, sout = old out[DATA_WIDTH-1].
- Shift results are not range-checked against MAX_VALUE. A subsequent inc on out > MAX_VALUE follows the out >= MAX_VALUE rule.
- Hold (no control active): out unchanged, bnd = 0, sout = 0.
- No X propagation: every control input is treated as a plain 1/0. Unused serial inputs have no effect.

Decomposition:
- Shared package/header reg_ctr_defs:
  - Operation-select encoding: OP_HOLD, OP_CLR, OP_LD, OP_INC, OP_DEC, OP_SHR, OP_SHL.
  - The priority resolution function mapping (cl, ld, inc, dec, sr, sl) to an op.
- One natural sub-module, reg_ctr_next: combinational next-state plus flag computation from op, out, in, ir, il.
- reg_ctr holds only the state registers for out, bnd and sout, plus the zero decode.

Test Plan (DATA_WIDTH=8 unless noted):
- Reset: ld=1, in=0x5A for one edge, then assert rst_n=0 between edges -> out=0x00, bnd=0, sout=0 immediately without a clock edge. RESET_VALUE=0x10 build -> out=0x10.
- Wrap count, MAX_VALUE=9, SATURATE=0:
  - ld 8, then inc x2 -> out 9 then 0; bnd=1 on the cycle after the wrap only.
  - dec at 0 -> out=9, bnd=1.
- Saturate, SATURATE=1, MAX_VALUE=255:
  - ld 0xFE, inc x3 -> out 0xFF, 0xFF, 0xFF; bnd=0,1,1.
  - ld 0x00, dec -> out 0x00, bnd=1, zero=1.
- Priority:
  - cl=ld=inc=1, in=0x33 -> out=RESET_VALUE.
  - ld=inc=1, in=0x33 -> out=0x33.
  - inc=dec=sr=1 with out=0x40 -> out=0x40, sout=0.
- Shifts:
  - out=0x81, sr with ir=0 -> out=0x40, sout=1.
  - Then sl with il=1 -> out=0x81, sout=0.
  - Eight sl with il=1 from 0x00 -> 0xFF.
- Width generality, DATA_WIDTH=16, MAX_VALUE=0xFFFF: ld 0xFFFF, inc -> out=0x0000, zero=1, bnd=1.
